// File: rtl/layer_out_serializer_if.sv
// Bus between a neuron layer, the layer_out_serializer, and the next layer's shared input.
// master = upstream layer / downstream consumer side, slave = serializer side.
interface layer_out_serializer_if #(
    parameter int unsigned NUM_NEURON = 30,
    parameter int unsigned DATA_WIDTH = 16
);
    logic [NUM_NEURON*DATA_WIDTH-1:0] in_data;
    logic [NUM_NEURON-1:0]            in_valid;
    logic [DATA_WIDTH-1:0]            out_data;
    logic                             out_valid;
    logic                             out_last;

    modport master (
        output in_data, in_valid,
        input  out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid,
        output out_data, out_valid, out_last
    );
endinterface

// File: rtl/layer_out_serializer.sv
// Double-buffered collector of per-neuron activations, streamed one per clock to the next layer.
// Optional SER_ARGMAX_EN adds a per-frame argmax (argmax_idx/argmax_valid).
module layer_out_serializer #(
    parameter int unsigned NUM_NEURON = 30,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    layer_out_serializer_if.slave bus,
    output logic                  busy,
    output logic                  overflow
`ifdef SER_ARGMAX_EN
    ,
    output logic [7:0]            argmax_idx,
    output logic                  argmax_valid
`endif
);
    localparam int unsigned IDX_W = $clog2(NUM_NEURON);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURON - 1);

    typedef enum logic {IDLE, SHIFT} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] cap_buf_q [NUM_NEURON];
    logic [DATA_WIDTH-1:0] cap_buf_d [NUM_NEURON];
    logic [DATA_WIDTH-1:0] shift_buf_q [NUM_NEURON];
    logic [DATA_WIDTH-1:0] shift_buf_d [NUM_NEURON];
    logic [NUM_NEURON-1:0] cap_mask_q, cap_mask_d;
    logic                  pend_q, pend_d;
    logic [IDX_W-1:0]      idx_q, idx_d, idx_nxt;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;
    logic                  busy_q, busy_d;
    logic                  overflow_q, overflow_d;
    logic                  load;

    assign idx_nxt = idx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cap_buf_d   = cap_buf_q;
        shift_buf_d = shift_buf_q;
        cap_mask_d  = cap_mask_q;
        pend_d      = pend_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        overflow_d  = overflow_q;
        load        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pend_q) load = 1'b1;
            end
            SHIFT: begin
                if (idx_q == LAST_IDX) begin
                    if (pend_q) begin
                        load = 1'b1;
                    end else begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end
                end else begin
                    idx_d      = idx_nxt;
                    out_data_d = shift_buf_q[idx_nxt];
                    out_last_d = (idx_nxt == LAST_IDX);
                end
            end
            default: ;
        endcase

        if (load) begin
            state_d     = SHIFT;
            shift_buf_d = cap_buf_q;
            cap_mask_d  = '0;
            pend_d      = 1'b0;
            idx_d       = '0;
            out_data_d  = cap_buf_q[0];
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
        end

        // Capture sees the mask/pend already cleared by a same-edge transfer.
        for (int unsigned k = 0; k < NUM_NEURON; k++) begin
            if (bus.in_valid[k]) begin
                if (!cap_mask_d[k] && !pend_d) begin
                    cap_buf_d[k]  = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
                    cap_mask_d[k] = 1'b1;
                end else begin
                    overflow_d = 1'b1;
                end
            end
        end
        if (&cap_mask_d) pend_d = 1'b1;

        busy_d = (state_d == SHIFT) || pend_d;
    end

    always_ff @(posedge clk) begin
        cap_buf_q   <= cap_buf_d;
        shift_buf_q <= shift_buf_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_mask_q  <= '0;
            pend_q      <= 1'b0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_mask_q  <= cap_mask_d;
            pend_q      <= pend_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign busy          = busy_q;
    assign overflow      = overflow_q;

`ifdef SER_ARGMAX_EN
    logic [DATA_WIDTH-1:0] max_val_q, max_val_d;
    logic [IDX_W-1:0]      max_idx_q, max_idx_d;
    logic [7:0]            argmax_idx_q, argmax_idx_d;
    logic                  argmax_valid_q, argmax_valid_d;

    // Compares the element currently on out_data; idx_q==0 marks a frame start.
    always_comb begin
        max_val_d      = max_val_q;
        max_idx_d      = max_idx_q;
        argmax_idx_d   = argmax_idx_q;
        argmax_valid_d = 1'b0;
        if (out_valid_q) begin
            if (idx_q == '0 || out_data_q > max_val_q) begin
                max_val_d = out_data_q;
                max_idx_d = idx_q;
            end
            if (out_last_q) begin
                argmax_idx_d   = 8'(max_idx_d);
                argmax_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            max_val_q      <= '0;
            max_idx_q      <= '0;
            argmax_idx_q   <= '0;
            argmax_valid_q <= 1'b0;
        end else begin
            max_val_q      <= max_val_d;
            max_idx_q      <= max_idx_d;
            argmax_idx_q   <= argmax_idx_d;
            argmax_valid_q <= argmax_valid_d;
        end
    end

    assign argmax_idx   = argmax_idx_q;
    assign argmax_valid = argmax_valid_q;
`endif
endmodule

// File: doc/layer_out_serializer.md
Name: layer_out_serializer

Overview:
- Sits between two neuron layers.
- Collects the 16-bit activation outputs of all NUM_NEURON neurons of one layer; each neuron's output is qualified by its own one-cycle valid pulse.
- Streams the collected activations one per clock into the next layer's shared input/valid bus.
- Double-buffered: the next layer's result can be collected while the current one is streaming out.

Parameters:
NUM_NEURON, 30, number of neurons in the upstream layer (2..256)
DATA_WIDTH, 16, width of one activation

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_data  in  NUM_NEURON*DATA_WIDTH  packed neuron outputs; neuron k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
in_valid  in  NUM_NEURON  per-neuron output-valid pulses
out_data  out  DATA_WIDTH  serialized activation to the next layer
out_valid  out  1  out_data valid this cycle
out_last  out  1  high with the final element (index NUM_NEURON-1) of a frame
busy  out  1  high while in SHIFT state or while pend is set
overflow  out  1  sticky error flag; cleared only by rst

Behaviour:
- Storage:
  - cap_buf: NUM_NEURON x DATA_WIDTH capture buffer.
  - cap_mask: NUM_NEURON bits.
  - pend: 1-bit flag, "cap_buf complete".
  - shift_buf: NUM_NEURON x DATA_WIDTH.
  - idx: counter of ceil(log2 NUM_NEURON) bits.
  - All outputs are registered.
- Capture, at each edge, for each k with in_valid[k]=1:
  - If cap_mask[k]=0 and pend=0: cap_buf[k] <= in_data slice k; cap_mask[k] <= 1.
  - Otherwise: data dropped; overflow <= 1.
  - Bits arriving in the same cycle are all captured.
- pend is set at the edge where cap_mask would become all-ones, including when the last bits arrive simultaneously.
- FSM states: IDLE, SHIFT.
  - IDLE with pend=1: shift_buf <= cap_buf; cap_mask <= 0; pend <= 0; idx <= 0; go to SHIFT.
    - At that same edge: out_data <= element 0, out_valid <= 1.
  - SHIFT: each edge, idx increments and out_data <= shift_buf[idx+1].
    - out_last is registered high with element NUM_NEURON-1.
    - On the edge after the last element: if pend=1, reload immediately (element 0 of the new frame, no bubble, stay in SHIFT). Otherwise return to IDLE with out_valid <= 0 and out_last <= 0.
- Latency:
  - Last capture at edge T, engine IDLE: first out_valid at edge T+1.
  - Frame spans exactly NUM_NEURON consecutive valid cycles.
- Simultaneous events: in_valid bits sampled at the edge where cap_mask clears (transfer) are captured into the freshly cleared mask. This does not count as overflow.
- No backpressure: the downstream layer must accept one element per cycle.
- Reset values: out_data=0, out_valid=0, out_last=0, busy=0, overflow=0; cap_mask=0, pend=0, state=IDLE.
- Reset mid-frame: out_valid drops at the first edge with rst=1 and the partial frame is discarded. After rst deasserts, nothing is emitted until a complete new frame is captured.
- Element order is neuron index ascending: 0 first.

Optional Feature:
- Macro: SER_ARGMAX_EN
- When defined, adds outputs argmax_idx (8 bits) and argmax_valid (1 bit).
  - During SHIFT, a running unsigned compare is kept over emitted elements. Strictly-greater replaces the current maximum, so ties keep the lower index.
  - argmax_valid pulses for one cycle on the edge after out_last.
  - argmax_idx holds that frame's winner until the next pulse.
  - Both reset to 0.
- When not defined, these ports and the compare logic are absent; all other behaviour is identical.

Test Plan:
- NUM_NEURON=4; single frame. in_valid=4'b1111 in one cycle with data {0x0004,0x0003,0x0002,0x0001} (neuron3..neuron0) -> next cycle out_valid=1 for 4 cycles. out_data sequence 0x0001,0x0002,0x0003,0x0004; out_last only on 0x0004; busy drops after the last element.
- Staggered arrival: neuron 2 at cycle 0, neurons 0 and 3 at cycle 5, neuron 1 at cycle 9 -> first out_valid at cycle 10, ordered by neuron index, overflow=0.
- Back-to-back: second full frame captured while the first frame is streaming -> 8 consecutive out_valid cycles with no gap; out_last at positions 4 and 8.
- Overflow: second in_valid[1] pulse before the frame completes -> overflow=1 and stays 1; the first neuron-1 value is emitted. Then rst -> overflow=0.
- Reset mid-frame: rst asserted after 2 elements out -> out_valid=0 at that edge. A new frame after reset emits all 4 elements correctly.
- SER_ARGMAX_EN with data {0x0100,0x7F00,0x7F00,0x0010} (neuron0..3) -> argmax_idx=1, argmax_valid for one cycle after out_last.
